// File: rtl/event_encoder_pkg.sv
// Shared definitions for the event encoder family: sizing helpers,
// popcount and the presentation-state encoding.
package enc_pkg;

    localparam int ENC_DEFAULT_N  = 8;
    localparam int ENC_DEFAULT_CW = 8;

    // Output register state: IDLE means nothing is presented.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } enc_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Index width for an N-input encoder; at least one bit.
    function automatic int enc_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Number of set bits; callers zero-extend narrower vectors.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/event_encoder_if.sv
// Bundle of event inputs, handshake and status signals of event_encoder.
// Handshake: oValid/oData are driven from registers; a transfer happens on
// a rising edge where oValid and iReady are both 1. While oValid is 1 and
// iReady is 0, oData and oValid are held stable (no retraction).
interface event_encoder_if
    import enc_pkg::*;
#(
    parameter int N  = ENC_DEFAULT_N,
    parameter int CW = ENC_DEFAULT_CW
) ();

    localparam int W = enc_width(N);

    logic [N-1:0]  iData;
    logic [N-1:0]  iMask;
    logic          iReady;
    logic [W-1:0]  oData;
    logic          oValid;
    logic [N-1:0]  oPending;
    logic          oOverflow;
    logic [CW-1:0] oDropCnt;
    enc_state_e    state;

    // Event source / consumer side.
    modport master (
        output iData, iMask, iReady,
        input  oData, oValid, oPending, oOverflow, oDropCnt, state
    );

    // Encoder side.
    modport slave (
        input  iData, iMask, iReady,
        output oData, oValid, oPending, oOverflow, oDropCnt, state
    );

endinterface

// File: rtl/event_encoder_prio_enc.sv
// Combinational N->W priority encoder. MSB_FIRST=1 picks the highest set
// bit, MSB_FIRST=0 the lowest. idx is 0 when no request is set.
module prio_enc
    import enc_pkg::*;
#(
    parameter int N         = ENC_DEFAULT_N,
    parameter int MSB_FIRST = 1,
    localparam int W        = enc_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan so that the winning bit is the last one written.
    always_comb begin
        idx = '0;
        any = |req;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Registered priority encoder with sticky event capture. Events set bits
// in a pending register; the highest-priority unmasked pending bit is
// presented as an index and cleared when the consumer accepts it. Events
// that hit an already-pending bit are counted as lost.
module event_encoder
    import enc_pkg::*;
#(
    parameter int N         = ENC_DEFAULT_N,
    parameter int MSB_FIRST = 1,
    parameter int CW        = ENC_DEFAULT_CW
) (
    input  logic           iClk,
    input  logic           iRst,
    event_encoder_if.slave bus
);

    localparam int W  = enc_width(N);
    // Sum width wide enough that counter + popcount never wraps.
    localparam int SW = CW + clog2(N) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    enc_state_e    state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [N-1:0]  pend_q;
    logic          ovf_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic [N-1:0]  clr;
    logic [N-1:0]  p_next;
    logic [N-1:0]  loss;
    logic [N-1:0]  elig;
    logic [W-1:0]  enc_idx;
    logic          enc_any;
    logic [SW-1:0] cnt_sum;
    logic [CW-1:0] cnt_next;

    // Pending-register next value, loss vector and saturating count.
    // A new event on the bit being cleared keeps it set and is not a loss.
    always_comb begin
        accept = (state_q == ST_PRESENT) && bus.iReady;
        for (int i = 0; i < N; i++) begin
            clr[i] = accept && (data_q == W'(i));
        end
        p_next   = (pend_q & ~clr) | bus.iData;
        loss     = bus.iData & pend_q & ~clr;
        elig     = p_next & ~bus.iMask;
        cnt_sum  = SW'(cnt_q) + SW'(popcount(64'(loss)));
        cnt_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CW-1:0];
    end

    prio_enc #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .req (elig),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Presentation FSM: reload the output register whenever it is free
    // (idle) or being accepted; otherwise hold regardless of inputs.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                state_d = enc_any ? ST_PRESENT : ST_IDLE;
                data_d  = enc_any ? enc_idx : '0;
            end
            ST_PRESENT: begin
                if (bus.iReady) begin
                    state_d = enc_any ? ST_PRESENT : ST_IDLE;
                    data_d  = enc_any ? enc_idx : '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = '0;
            end
        endcase
    end

    // All state registers; reset discards pending and presented events.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pend_q  <= p_next;
            ovf_q   <= |loss;
            cnt_q   <= cnt_next;
        end
    end

    assign bus.oValid    = (state_q == ST_PRESENT);
    assign bus.oData     = data_q;
    assign bus.oPending  = pend_q;
    assign bus.oOverflow = ovf_q;
    assign bus.oDropCnt  = cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder (N=8, CW=8). Two instances share the
// same stimulus: dut_hi uses MSB_FIRST=1, dut_lo uses MSB_FIRST=0.
module tb_event_encoder;
    import enc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    event_encoder_if #(.N(8), .CW(8)) bus_hi ();
    event_encoder_if #(.N(8), .CW(8)) bus_lo ();

    event_encoder #(.N(8), .MSB_FIRST(1), .CW(8)) dut_hi (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_hi.slave)
    );

    event_encoder #(.N(8), .MSB_FIRST(0), .CW(8)) dut_lo (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_lo.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs at the falling edge, then sample 1 time unit after the
    // following rising edge.
    task automatic apply(input logic r, input logic [7:0] d, input logic [7:0] m, input logic rdy);
        @(negedge clk);
        rst           = r;
        bus_hi.iData  = d;
        bus_hi.iMask  = m;
        bus_hi.iReady = rdy;
        bus_lo.iData  = d;
        bus_lo.iMask  = m;
        bus_lo.iReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_hi(input string tag, input logic v, input logic [2:0] o,
                            input logic [7:0] p, input logic ov, input logic [7:0] dc);
        check({tag, ".valid"},   64'(bus_hi.oValid),    64'(v));
        check({tag, ".data"},    64'(bus_hi.oData),     64'(o));
        check({tag, ".pending"}, 64'(bus_hi.oPending),  64'(p));
        check({tag, ".ovf"},     64'(bus_hi.oOverflow), 64'(ov));
        check({tag, ".dropcnt"}, 64'(bus_hi.oDropCnt),  64'(dc));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] data;
        logic [7:0] mask;
        logic       ready;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       ovf;
        logic [7:0] cnt;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic [7:0] d, input logic [7:0] m,
                                input logic rdy, input logic v, input logic [2:0] o,
                                input logic [7:0] p, input logic ov, input logic [7:0] dc);
        vec_t t;
        t.rst = r; t.data = d; t.mask = m; t.ready = rdy;
        t.valid = v; t.idx = o; t.pend = p; t.ovf = ov; t.cnt = dc;
        return t;
    endfunction

    initial begin
        bus_hi.iData = '0; bus_hi.iMask = '0; bus_hi.iReady = 1'b0;
        bus_lo.iData = '0; bus_lo.iMask = '0; bus_lo.iReady = 1'b0;

        //               rst data   mask   rdy  v  idx  pend   ov dc
        // reset and single event
        vecs[0]  = mk(1, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 8'h04, 8'h00, 1,  1, 2, 8'h04, 0, 0);
        vecs[2]  = mk(0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 0, 0);
        // priority order 7,4,0
        vecs[3]  = mk(0, 8'h91, 8'h00, 1,  1, 7, 8'h91, 0, 0);
        vecs[4]  = mk(0, 8'h00, 8'h00, 1,  1, 4, 8'h11, 0, 0);
        vecs[5]  = mk(0, 8'h00, 8'h00, 1,  1, 0, 8'h01, 0, 0);
        vecs[6]  = mk(0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 0, 0);
        // backpressure hold on index 5, bit 7 arrives meanwhile
        vecs[7]  = mk(0, 8'h20, 8'h00, 0,  1, 5, 8'h20, 0, 0);
        vecs[8]  = mk(0, 8'h80, 8'h00, 0,  1, 5, 8'hA0, 0, 0);
        vecs[9]  = mk(0, 8'h00, 8'h00, 0,  1, 5, 8'hA0, 0, 0);
        vecs[10] = mk(0, 8'h00, 8'h00, 0,  1, 5, 8'hA0, 0, 0);
        vecs[11] = mk(0, 8'h00, 8'h00, 1,  1, 7, 8'h80, 0, 0);
        vecs[12] = mk(0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 0, 0);
        // masking: bit 7 stays pending until unmasked
        vecs[13] = mk(0, 8'h81, 8'h80, 1,  1, 0, 8'h81, 0, 0);
        vecs[14] = mk(0, 8'h00, 8'h80, 1,  0, 0, 8'h80, 0, 0);
        vecs[15] = mk(0, 8'h00, 8'h80, 1,  0, 0, 8'h80, 0, 0);
        vecs[16] = mk(0, 8'h00, 8'h00, 0,  1, 7, 8'h80, 0, 0);
        vecs[17] = mk(0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 0, 0);
        // masking the presented bit does not retract it
        vecs[18] = mk(0, 8'h80, 8'h00, 0,  1, 7, 8'h80, 0, 0);
        vecs[19] = mk(0, 8'h00, 8'h80, 0,  1, 7, 8'h80, 0, 0);
        vecs[20] = mk(0, 8'h00, 8'h80, 1,  0, 0, 8'h00, 0, 0);
        // overflow pulse, then event coinciding with accept of the same bit
        vecs[21] = mk(0, 8'h08, 8'h00, 0,  1, 3, 8'h08, 0, 0);
        vecs[22] = mk(0, 8'h08, 8'h00, 0,  1, 3, 8'h08, 1, 1);
        vecs[23] = mk(0, 8'h00, 8'h00, 0,  1, 3, 8'h08, 0, 1);
        vecs[24] = mk(0, 8'h08, 8'h00, 1,  1, 3, 8'h08, 0, 1);
        vecs[25] = mk(0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 0, 1);
        // several losses in one cycle (popcount > 1)
        vecs[26] = mk(0, 8'h0F, 8'h00, 0,  1, 3, 8'h0F, 0, 1);
        vecs[27] = mk(0, 8'h0F, 8'h00, 0,  1, 3, 8'h0F, 1, 5);
        vecs[28] = mk(0, 8'h0F, 8'h00, 1,  1, 3, 8'h0F, 1, 8);
        vecs[29] = mk(0, 8'h00, 8'h00, 1,  1, 2, 8'h07, 0, 8);
        vecs[30] = mk(0, 8'h00, 8'h00, 1,  1, 1, 8'h03, 0, 8);
        vecs[31] = mk(0, 8'h00, 8'h00, 1,  1, 0, 8'h01, 0, 8);
        vecs[32] = mk(0, 8'h00, 8'h00, 1,  0, 0, 8'h00, 0, 8);

        // ---------------- table-driven part ----------------
        for (int k = 0; k < NV; k++) begin
            apply(vecs[k].rst, vecs[k].data, vecs[k].mask, vecs[k].ready);
            check_hi($sformatf("vec%0d", k), vecs[k].valid, vecs[k].idx,
                     vecs[k].pend, vecs[k].ovf, vecs[k].cnt);
            check($sformatf("vec%0d.state", k), 64'(bus_hi.state == ST_PRESENT), 64'(vecs[k].valid));
        end

        // ---------------- lowest-first ordering on dut_lo ----------------
        apply(1, 8'h00, 8'h00, 0);
        check("lo.reset.valid", 64'(bus_lo.oValid), 64'(0));
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd7);
        apply(0, 8'h91, 8'h00, 1);
        for (int k = 0; k < 3; k++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check($sformatf("lo.order%0d.valid", k), 64'(bus_lo.oValid), 64'(1));
            check($sformatf("lo.order%0d.data", k), 64'(bus_lo.oData), 64'(e));
            apply(0, 8'h00, 8'h00, 1);
        end
        check("lo.drained.valid", 64'(bus_lo.oValid), 64'(0));
        check("lo.drained.pending", 64'(bus_lo.oPending), 64'(0));

        // ---------------- drop counter saturation ----------------
        apply(1, 8'h00, 8'h00, 0);
        check_hi("sat.reset", 0, 0, 8'h00, 0, 0);
        begin
            int exp_cnt;
            exp_cnt = 0;
            // first cycle captures bit 3, the next 300 are losses
            for (int k = 0; k <= 300; k++) begin
                apply(0, 8'h08, 8'h00, 0);
                if (k > 0 && exp_cnt < 255) exp_cnt++;
                check($sformatf("sat%0d.dropcnt", k), 64'(bus_hi.oDropCnt), 64'(exp_cnt));
                check($sformatf("sat%0d.ovf", k), 64'(bus_hi.oOverflow), 64'(k > 0));
            end
        end

        // ---------------- reset mid-operation ----------------
        apply(0, 8'hFF, 8'h00, 0);
        check_hi("mid.full", 1, 3, 8'hFF, 1, 8'd255);
        apply(1, 8'hFF, 8'h00, 0);
        check_hi("mid.rst", 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            apply(0, 8'h00, 8'h00, 1);
            check_hi($sformatf("mid.after%0d", k), 0, 0, 8'h00, 0, 0);
        end

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
